// File: rtl/digit_box_reader.sv
// Raster-order readback of a rectangular digit box from a 1-bit frame buffer.
// Pixels go out over a valid/ready stream, and each pixel is tagged with row-start, row-end and box-end flags.
module digit_box_reader #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        left_in,
  input  logic [8:0]        right_in,
  input  logic [8:0]        top_in,
  input  logic [8:0]        bottom_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done,
  output logic              err_box
);

  localparam logic [8:0]        MAX_COL = 9'(IMG_W - 1);
  localparam logic [8:0]        MAX_ROW = 9'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        left_q, right_q, top_q, bottom_q;
  logic [8:0]        left_d, right_d, top_d, bottom_d;
  logic [8:0]        col_q, row_q, col_d, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              err_q, err_d;

  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              pix_valid_d, pix_data_d, pix_sol_d, pix_eol_d, pix_eof_d;
  logic              busy_d, done_d, err_box_d;

  // NOTE: every signal gets a hold-value default before the case so that no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    top_d       = top_q;
    bottom_d    = bottom_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    err_d       = err_q;
    pix_valid_d = pix_valid;
    pix_data_d  = pix_data;
    pix_sol_d   = pix_sol;
    pix_eol_d   = pix_eol;
    pix_eof_d   = pix_eof;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          left_d   = left_in;
          right_d  = (right_in > MAX_COL) ? MAX_COL : right_in;
          top_d    = top_in;
          bottom_d = (bottom_in > MAX_ROW) ? MAX_ROW : bottom_in;
          err_d    = 1'b0;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((left_q > right_q) || (top_q > bottom_q)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          col_d      = left_q;
          row_d      = top_q;
          row_base_d = ADDR_W'(top_q) * STRIDE;
          state_d    = S_READ;
        end
      end

      S_READ: state_d = S_WAIT;

      S_WAIT: begin
        pix_data_d  = rd_data;
        pix_sol_d   = (col_q == left_q);
        pix_eol_d   = (col_q == right_q);
        pix_eof_d   = (col_q == right_q) && (row_q == bottom_q);
        pix_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_eof) begin
            state_d = S_FIN;
          end else if (col_q == right_q) begin
            col_d      = left_q;
            row_d      = row_q + 9'd1;
            row_base_d = row_base_q + STRIDE;
            state_d    = S_READ;
          end else begin
            col_d   = col_q + 9'd1;
            state_d = S_READ;
          end
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // The read strobe and the status outputs are registered from the next state, so they line up with the state they describe.
    rd_en_d   = (state_d == S_READ);
    rd_addr_d = rd_en_d ? (row_base_d + ADDR_W'(col_d)) : rd_addr;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    err_box_d = done_d && err_d;
  end

  // NOTE: all state uses non-blocking assignment, so every register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      left_q     <= '0;
      right_q    <= '0;
      top_q      <= '0;
      bottom_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      err_q      <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= 1'b0;
      pix_sol    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_eof    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_box    <= 1'b0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      right_q    <= right_d;
      top_q      <= top_d;
      bottom_q   <= bottom_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      err_q      <= err_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      pix_valid  <= pix_valid_d;
      pix_data   <= pix_data_d;
      pix_sol    <= pix_sol_d;
      pix_eol    <= pix_eol_d;
      pix_eof    <= pix_eof_d;
      busy       <= busy_d;
      done       <= done_d;
      err_box    <= err_box_d;
    end
  end

endmodule

// File: tb/tb_digit_box_reader.sv
// Scoreboard bench for digit_box_reader: stimulus pushes expected reads/pixels/done events,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_digit_box_reader;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [8:0]        left_in = '0, right_in = '0, top_in = '0, bottom_in = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data = 1'b0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic              pix_data, pix_sol, pix_eol, pix_eof;
  logic              busy, done, err_box;

  digit_box_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .left_in(left_in), .right_in(right_in), .top_in(top_in), .bottom_in(bottom_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .done(done), .err_box(err_box)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic data;
    logic sol;
    logic eol;
    logic eof;
  } pix_t;

  pix_t              exp_pix[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic              exp_done[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_rise = 0;
  int last_hs = 0;
  int hs_count = 0;
  bit first_rise = 1'b0;
  bit full_speed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ram_bit(input logic [ADDR_W-1:0] a);
    return a[0] ^ a[2] ^ a[6];
  endfunction

  // Frame-buffer model: one-cycle read latency.
  always @(posedge clock) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? ram_bit(rd_addr) : 1'b0;
  end

  // Monitor
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  pix_t prev_pix = '0;

  always @(negedge clock) begin
    pix_t cur;
    logic e;
    cur = '{data: pix_data, sol: pix_sol, eol: pix_eol, eof: pix_eof};
    if (rst_n) begin
      if (rd_en) begin
        check("rd_en_while_valid", pix_valid, 1'b0);
        if (exp_addr.size() == 0) check("unexpected_rd_en", rd_addr, 32'hFFFF_FFFF);
        else check("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (prev_stall) begin
        check("stall_valid", pix_valid, 1'b1);
        check("stall_pix", cur, prev_pix);
      end
      if (pix_valid && !prev_valid) begin
        if (full_speed) begin
          if (first_rise) check("first_valid_latency", cyc, start_cyc + 4);
          else check("valid_spacing", cyc, last_rise + 3);
        end
        first_rise = 1'b0;
        last_rise  = cyc;
      end
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) check("unexpected_pixel", cur, 5'h1F);
        else check("pixel{data,sol,eol,eof}", cur, exp_pix.pop_front());
        last_hs = cyc;
        hs_count++;
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", done, 1'b0);
        else begin
          e = exp_done.pop_front();
          check("err_box", err_box, e);
          if (e) check("err_done_latency", cyc, start_cyc + 2);
          else check("done_after_last_pixel", cyc, last_hs + 1);
        end
      end else if (err_box) begin
        check("err_box_without_done", err_box, 1'b0);
      end
      prev_valid = pix_valid;
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
    end else begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_outputs"},
          {rd_en, pix_valid, pix_data, pix_sol, pix_eol, pix_eof, busy, done, err_box}, 9'd0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // The clamped bounds cr/cb are passed in already worked out by hand.
  task automatic run_box(input logic [8:0] l, r, t, b, cr, cb, input bit err, input bit fs);
    logic [ADDR_W-1:0] a;
    full_speed = fs;
    if (!err) begin
      for (int row = int'(t); row <= int'(cb); row++) begin
        for (int col = int'(l); col <= int'(cr); col++) begin
          a = ADDR_W'(row * IMG_W + col);
          exp_addr.push_back(a);
          exp_pix.push_back('{data: ram_bit(a), sol: (col == int'(l)), eol: (col == int'(cr)),
                              eof: (col == int'(cr)) && (row == int'(cb))});
        end
      end
    end
    exp_done.push_back(err);
    @(posedge clock); #1;
    start = 1'b1; left_in = l; right_in = r; top_in = t; bottom_in = b;
    start_cyc  = cyc;
    first_rise = 1'b1;
    check("busy_in_start_cycle", busy, 1'b0);
    @(posedge clock); #1;
    start = 1'b0; left_in = 9'd7; right_in = 9'd3; top_in = 9'd9; bottom_in = 9'd1;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check({tag, "_busy_cleared"}, busy, 1'b0);
    @(negedge clock);
    check({tag, "_pixels_left"}, exp_pix.size(), 0);
    check({tag, "_reads_left"}, exp_addr.size(), 0);
    check({tag, "_dones_left"}, exp_done.size(), 0);
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 60; i++) begin
      if (hs_count >= target) break;
      @(negedge clock);
    end
    check("handshake_wait", hs_count >= target, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1 rst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic box, full speed: reads 1610..1612 then 1930..1932
    run_box(9'd10, 9'd12, 9'd5, 9'd6, 9'd12, 9'd6, 1'b0, 1'b1);
    wait_idle("basic");

    // Backpressure: pixel 2 held off for 5 cycles
    run_box(9'd10, 9'd12, 9'd5, 9'd6, 9'd12, 9'd6, 1'b0, 1'b0);
    wait_hs(hs_count + 1);
    @(posedge clock); #1 pix_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pix_valid) break;
    end
    check("stall_pixel_presented", pix_valid, 1'b1);
    repeat (5) @(posedge clock);
    #1 pix_ready = 1'b1;
    wait_idle("backpressure");

    // Invalid box
    run_box(9'd20, 9'd10, 9'd5, 9'd6, 9'd10, 9'd6, 1'b1, 1'b1);
    wait_idle("invalid");

    // Clamping: only 76798 and 76799
    run_box(9'd318, 9'd400, 9'd239, 9'd300, 9'd319, 9'd239, 1'b0, 1'b1);
    wait_idle("clamp");

    // Single pixel at origin
    run_box(9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1);
    wait_idle("single");

    // Start mid-box and in the done cycle must both be ignored
    run_box(9'd10, 9'd12, 9'd5, 9'd6, 9'd12, 9'd6, 1'b0, 1'b1);
    repeat (5) @(posedge clock);
    #1 start = 1'b1; left_in = 9'd0; right_in = 9'd0; top_in = 9'd0; bottom_in = 9'd0;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (2) @(negedge clock);
    check("start_in_done_cycle_ignored", busy, 1'b0);
    wait_idle("ignored_start");

    // Asynchronous reset mid-box, then a fresh box
    run_box(9'd10, 9'd12, 9'd5, 9'd6, 9'd12, 9'd6, 1'b0, 1'b1);
    repeat (6) @(posedge clock);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    exp_pix.delete();
    exp_addr.delete();
    exp_done.delete();
    @(posedge clock); #1 rst_n = 1'b1;
    run_box(9'd100, 9'd101, 9'd50, 9'd51, 9'd101, 9'd51, 1'b0, 1'b1);
    wait_idle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
